// File: rtl/forward_hazard_ctrl.sv
// EX operand forwarding selects plus load-use stall, tracked from shadow EX/MEM/WB destination state.
// Forward selects come from registered state only; stall is combinational from ID + EX; flush overrides stall.
module forward_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ZERO_REG   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_uses_rt,
    input  logic                  flush,
    output logic [1:0]            ex_fwd_a,
    output logic [1:0]            ex_fwd_b,
    output logic                  stall
);

    localparam logic [REG_ADDR_W-1:0] ZR = REG_ADDR_W'(ZERO_REG);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } ex_sh_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
    } dst_sh_t;

    ex_sh_t  ex_q, ex_d;
    dst_sh_t mem_q, mem_d;
    dst_sh_t wb_q, wb_d;

    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic ex_is_load;

    always_comb begin
        mem_hit_a  = mem_q.regwrite && (mem_q.rd != ZR) && (mem_q.rd == ex_q.rs);
        mem_hit_b  = mem_q.regwrite && (mem_q.rd != ZR) && (mem_q.rd == ex_q.rt);
        wb_hit_a   = wb_q.regwrite  && (wb_q.rd  != ZR) && (wb_q.rd  == ex_q.rs);
        wb_hit_b   = wb_q.regwrite  && (wb_q.rd  != ZR) && (wb_q.rd  == ex_q.rt);

        // MEM is the youngest producer, so it wins over WB
        ex_fwd_a = 2'b00;
        if (mem_hit_a)     ex_fwd_a = 2'b01;
        else if (wb_hit_a) ex_fwd_a = 2'b10;

        ex_fwd_b = 2'b00;
        if (mem_hit_b)     ex_fwd_b = 2'b01;
        else if (wb_hit_b) ex_fwd_b = 2'b10;

        ex_is_load = ex_q.memread && ex_q.regwrite && (ex_q.rd != ZR);
        stall      = ex_is_load && !flush &&
                     ((ex_q.rd == id_rs) || (id_uses_rt && (ex_q.rd == id_rt)));
    end

    always_comb begin
        ex_d = '{rs: ZR, rt: ZR, rd: ZR, regwrite: 1'b0, memread: 1'b0};
        if (!stall && !flush) begin
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
        end
        // MEM/WB keep advancing even while a bubble is injected into EX
        mem_d.rd       = ex_q.rd;
        mem_d.regwrite = ex_q.regwrite;
        wb_d           = mem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '{rs: ZR, rt: ZR, rd: ZR, regwrite: 1'b0, memread: 1'b0};
            mem_q <= '{rd: ZR, regwrite: 1'b0};
            wb_q  <= '{rd: ZR, regwrite: 1'b0};
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Scoreboarded bench: driver predicts selects/stall from a queue of in-flight instructions, monitor compares.
module tb_forward_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_regwrite, id_memread, id_uses_rt, flush;
    logic [1:0] ex_fwd_a, ex_fwd_b;
    logic       stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       rw, mr;
    } instr_t;

    typedef struct {
        logic [1:0] fa, fb;
        logic       st;
    } exp_t;

    // Instructions that have entered EX, youngest first: [0]=EX, [1]=one stage on, [2]=two on
    instr_t hist[$];
    exp_t   exp_q[$];

    forward_hazard_ctrl #(.REG_ADDR_W(5), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_uses_rt(id_uses_rt),
        .flush(flush),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall(stall)
    );

    always #5 clk = ~clk;

    function automatic instr_t mk(input int rs, input int rt, input int rd, input int rw, input int mr);
        instr_t i;
        i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd); i.rw = 1'(rw); i.mr = 1'(mr);
        return i;
    endfunction

    // Result of the youngest older instruction writing src: one stage older -> 01, two older -> 10
    function automatic logic [1:0] fwd_for(input logic [4:0] src);
        for (int age = 1; age <= 2; age++)
            if (age < hist.size() && hist[age].rw && hist[age].rd != 5'd0 && hist[age].rd == src)
                return (age == 1) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic exp_t predict(input instr_t id, input logic ut, input logic fl);
        exp_t e;
        e.fa = 2'b00; e.fb = 2'b00; e.st = 1'b0;
        if (hist.size() > 0) begin
            e.fa = fwd_for(hist[0].rs);
            e.fb = fwd_for(hist[0].rt);
            e.st = !fl && hist[0].mr && hist[0].rw && hist[0].rd != 5'd0 &&
                   (hist[0].rd == id.rs || (ut && hist[0].rd == id.rt));
        end
        return e;
    endfunction

    // One cycle: drive ID, queue the expectation, take the edge, advance the model
    task automatic step(input instr_t id, input logic ut, input logic fl, input logic r,
                        output logic stalled);
        exp_t e;
        id_rs = id.rs; id_rt = id.rt; id_rd = id.rd;
        id_regwrite = id.rw; id_memread = id.mr; id_uses_rt = ut;
        flush = fl; rst = r;
        e = predict(id, ut, fl);
        exp_q.push_back(e);
        stalled = e.st;
        @(posedge clk);
        if (r) hist.delete();
        else begin
            hist.push_front((e.st || fl) ? mk(0, 0, 0, 0, 0) : id);
            if (hist.size() > 3) void'(hist.pop_back());
        end
        #1;
    endtask

    // Issue an instruction, re-presenting it while stalled; flush only on the first attempt
    task automatic issue(input instr_t id, input logic ut, input logic fl);
        logic st;
        int   tries = 0;
        step(id, ut, fl, 1'b0, st);
        while (st && !fl && tries < 4) begin
            tries++;
            step(id, ut, 1'b0, 1'b0, st);
        end
        if (tries > 1) begin
            errors++;
            $display("FAIL stall_persist: stalled %0d consecutive cycles, required at most 1", tries);
        end
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) issue(mk(0, 0, 0, 0, 0), 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 3;
                if (ex_fwd_a !== e.fa) begin
                    errors++;
                    $display("FAIL fwd_a @%0t: got %b, expected %b", $time, ex_fwd_a, e.fa);
                end
                if (ex_fwd_b !== e.fb) begin
                    errors++;
                    $display("FAIL fwd_b @%0t: got %b, expected %b", $time, ex_fwd_b, e.fb);
                end
                if (stall !== e.st) begin
                    errors++;
                    $display("FAIL stall @%0t: got %b, expected %b", $time, stall, e.st);
                end
            end
        end
    end

    initial begin : driver
        logic st;
        instr_t r;
        rst = 1'b1; flush = 1'b0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_regwrite = 1'b0; id_memread = 1'b0; id_uses_rt = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        hist.delete();

        // Reset state is covered by the first queued expectation
        nops(2);
        // Back-to-back ALU, then with one unrelated instruction between
        issue(mk(0, 0, 3, 1, 0), 1'b0, 1'b0);
        issue(mk(3, 4, 6, 1, 0), 1'b1, 1'b0);
        nops(3);
        issue(mk(0, 0, 3, 1, 0), 1'b0, 1'b0);
        issue(mk(1, 2, 8, 1, 0), 1'b1, 1'b0);
        issue(mk(3, 4, 6, 1, 0), 1'b1, 1'b0);
        nops(4);
        // Double producer on r5
        issue(mk(0, 0, 5, 1, 0), 1'b0, 1'b0);
        issue(mk(0, 0, 5, 1, 0), 1'b0, 1'b0);
        issue(mk(5, 5, 6, 1, 0), 1'b1, 1'b0);
        nops(3);
        // Zero register: never forwarded, never stalled on
        issue(mk(0, 0, 0, 1, 0), 1'b0, 1'b0);
        issue(mk(0, 1, 6, 1, 0), 1'b1, 1'b0);
        issue(mk(0, 0, 0, 1, 1), 1'b0, 1'b0);
        issue(mk(0, 0, 6, 1, 0), 1'b1, 1'b0);
        nops(3);
        // Load-use with and without rt in use
        issue(mk(0, 0, 7, 1, 1), 1'b0, 1'b0);
        issue(mk(1, 7, 10, 1, 0), 1'b1, 1'b0);
        nops(3);
        issue(mk(0, 0, 7, 1, 1), 1'b0, 1'b0);
        issue(mk(1, 7, 10, 1, 0), 1'b0, 1'b0);
        nops(3);
        // Flush in the would-be stall cycle
        issue(mk(0, 0, 7, 1, 1), 1'b0, 1'b0);
        issue(mk(1, 7, 7, 1, 0), 1'b1, 1'b1);
        issue(mk(7, 7, 11, 1, 0), 1'b1, 1'b0);
        nops(3);
        // Reset with r9 producer in flight
        issue(mk(0, 0, 9, 1, 0), 1'b0, 1'b0);
        nops(1);
        step(mk(0, 0, 0, 0, 0), 1'b0, 1'b0, 1'b1, st);
        issue(mk(9, 9, 12, 1, 0), 1'b1, 1'b0);
        nops(3);

        // Random traffic over a small register set for dense hazards
        for (int n = 0; n < 2000; n++) begin
            r = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? 1 : 0);
            if ($urandom_range(0, 99) == 0)
                step(r, 1'($urandom_range(0, 1)), 1'b0, 1'b1, st);
            else
                issue(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
